// File: rtl/asic_xfer_ctrl_pkg.sv
// Shared types and default parameter values for the ASIC transfer controller.
package asic_xfer_ctrl_pkg;

  localparam int DEF_DATA_W = 128;
  localparam int DEF_CNT_W  = 10;
  localparam int DEF_MODE_W = 3;
  localparam int DEF_TMO_W  = 16;
  localparam int LANE_W     = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    PAT_ZERO   = 2'd0,
    PAT_RAMP   = 2'd1,
    PAT_BYTE01 = 2'd2,
    PAT_ALT10  = 2'd3
  } pat_e;

endpackage

// File: rtl/asic_xfer_ctrl_pat_gen.sv
// Host-to-ASIC data pattern generator: pattern select and beat index to one bus word.
module xfer_pat_gen
  import asic_xfer_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  pat_e              pat,
  input  logic [CNT_W-1:0]  beat,
  output logic [DATA_W-1:0] word
);

  localparam int LANES = DATA_W / LANE_W;

  // Ramp lane 0 for this beat; lane k adds 2k, everything wraps at 16 bits.
  logic [LANE_W-1:0] ramp_base;
  assign ramp_base = LANE_W'(32'(beat) * 32'(2 * LANES));

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves word unassigned (no latch).
    word = '0;
    for (int k = 0; k < LANES; k++) begin
      case (pat)
        PAT_RAMP:   word[k*LANE_W +: LANE_W] = ramp_base + LANE_W'(2 * k);
        PAT_BYTE01: word[k*LANE_W +: LANE_W] = 16'h0101;
        PAT_ALT10:  word[k*LANE_W +: LANE_W] = 16'hAAAA;
        default:    word[k*LANE_W +: LANE_W] = '0;
      endcase
    end
  end

endmodule

// File: rtl/asic_xfer_ctrl.sv
// Table-driven transfer controller: one config handshake starts a counted burst in
// either direction on the shared bus, guarded by an idle-beat watchdog.
module asic_xfer_ctrl
  import asic_xfer_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int MODE_W = DEF_MODE_W,
  parameter int TMO_W  = DEF_TMO_W
) (
  input  logic                          I_clk,
  input  logic                          I_rst,
  input  logic                          I_cfg_val,
  output logic                          O_cfg_rdy,
  input  logic [DATA_W-1:0]             I_data,
  output logic [DATA_W-1:0]             O_data,
  output logic                          O_oe,
  output logic                          O_rd_val,
  input  logic                          I_rd_rdy,
  input  logic                          I_wr_val,
  output logic                          O_wr_rdy,
  input  logic [(2**MODE_W)*CNT_W-1:0]  I_len_tbl,
  input  logic [(2**MODE_W)-1:0]        I_dir_tbl,
  input  logic [(2**MODE_W)*2-1:0]      I_pat_tbl,
  output logic                          O_busy,
  output logic                          O_done,
  output logic                          O_timeout,
  output logic [MODE_W-1:0]             O_mode,
  output logic [CNT_W-1:0]              O_beat_cnt,
  output logic [DATA_W-1:0]             O_rx_sig
);

  state_e            state;
  logic [CNT_W-1:0]  len_q;
  logic              dir_q;
  pat_e              pat_q;
  logic [TMO_W-1:0]  wdog_q;

  logic [MODE_W-1:0] cfg_mode;
  logic              cfg_hs;
  logic              beat;
  logic              last_beat;
  logic              expire;
  logic [TMO_W-1:0]  wdog_inc;
  logic [CNT_W-1:0]  cnt_inc;
  logic [DATA_W-1:0] pat_word;

  assign cfg_mode  = I_data[MODE_W:1];
  assign cfg_hs    = I_cfg_val & O_cfg_rdy;
  // rd_val / wr_rdy are only ever high in XFER, so a beat implies XFER.
  assign beat      = (O_rd_val & I_rd_rdy) | (I_wr_val & O_wr_rdy);
  assign last_beat = beat && (O_beat_cnt == len_q);
  assign wdog_inc  = wdog_q + TMO_W'(1);
  assign expire    = !beat && (&wdog_inc);
  assign cnt_inc   = (&O_beat_cnt) ? O_beat_cnt : O_beat_cnt + CNT_W'(1);

  xfer_pat_gen #(
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) u_pat_gen (
    .pat (pat_q),
    .beat(O_beat_cnt),
    .word(pat_word)
  );

  assign O_data = O_oe ? pat_word : '0;

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state      <= ST_IDLE;
      len_q      <= '0;
      dir_q      <= 1'b0;
      pat_q      <= PAT_ZERO;
      wdog_q     <= '0;
      O_cfg_rdy  <= 1'b0;
      O_rd_val   <= 1'b0;
      O_wr_rdy   <= 1'b0;
      O_oe       <= 1'b0;
      O_busy     <= 1'b0;
      O_done     <= 1'b0;
      O_timeout  <= 1'b0;
      O_mode     <= '0;
      O_beat_cnt <= '0;
      O_rx_sig   <= '0;
    end else begin
      O_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          O_cfg_rdy <= 1'b1;
          if (cfg_hs) begin
            state      <= ST_XFER;
            O_mode     <= cfg_mode;
            len_q      <= I_len_tbl[int'(cfg_mode)*CNT_W +: CNT_W];
            dir_q      <= I_dir_tbl[cfg_mode];
            pat_q      <= pat_e'(I_pat_tbl[int'(cfg_mode)*2 +: 2]);
            O_beat_cnt <= '0;
            O_rx_sig   <= '0;
            wdog_q     <= '0;
            O_timeout  <= 1'b0;
            O_cfg_rdy  <= 1'b0;
            O_busy     <= 1'b1;
            O_rd_val   <= I_dir_tbl[cfg_mode];
            O_wr_rdy   <= !I_dir_tbl[cfg_mode];
            O_oe       <= I_dir_tbl[cfg_mode];
          end
        end
        ST_XFER: begin
          if (beat) begin
            O_beat_cnt <= cnt_inc;
            wdog_q     <= '0;
            if (!dir_q) O_rx_sig <= O_rx_sig ^ I_data;
          end else begin
            wdog_q <= wdog_inc;
          end
          if (last_beat || expire) begin
            state    <= ST_DONE;
            O_done   <= 1'b1;
            O_rd_val <= 1'b0;
            O_wr_rdy <= 1'b0;
            O_oe     <= 1'b0;
            if (expire) O_timeout <= 1'b1;
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          O_busy    <= 1'b0;
          O_cfg_rdy <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_asic_xfer_ctrl.sv
// Randomized self-checking bench for asic_xfer_ctrl against a transfer-level reference model.
module tb_asic_xfer_ctrl;

  localparam int DATA_W    = 128;
  localparam int CNT_W     = 10;
  localparam int MODE_W    = 3;
  localparam int TMO_W     = 4;
  localparam int NUM_MODES = 2 ** MODE_W;
  localparam int LANES     = DATA_W / 16;
  localparam int TMO_IDLE  = (2 ** TMO_W) - 1;
  localparam int CNT_MAX   = (2 ** CNT_W) - 1;

  localparam int P_ALWAYS  = 0;
  localparam int P_RANDOM  = 1;
  localparam int P_NEVER   = 2;
  localparam int P_EVERY15 = 3;
  localparam int P_TOGGLE  = 4;

  logic                        I_clk;
  logic                        I_rst;
  logic                        I_cfg_val;
  logic                        O_cfg_rdy;
  logic [DATA_W-1:0]           I_data;
  logic [DATA_W-1:0]           O_data;
  logic                        O_oe;
  logic                        O_rd_val;
  logic                        I_rd_rdy;
  logic                        I_wr_val;
  logic                        O_wr_rdy;
  logic [NUM_MODES*CNT_W-1:0]  I_len_tbl;
  logic [NUM_MODES-1:0]        I_dir_tbl;
  logic [NUM_MODES*2-1:0]      I_pat_tbl;
  logic                        O_busy;
  logic                        O_done;
  logic                        O_timeout;
  logic [MODE_W-1:0]           O_mode;
  logic [CNT_W-1:0]            O_beat_cnt;
  logic [DATA_W-1:0]           O_rx_sig;

  asic_xfer_ctrl #(
    .DATA_W(DATA_W),
    .CNT_W (CNT_W),
    .MODE_W(MODE_W),
    .TMO_W (TMO_W)
  ) dut (
    .I_clk     (I_clk),
    .I_rst     (I_rst),
    .I_cfg_val (I_cfg_val),
    .O_cfg_rdy (O_cfg_rdy),
    .I_data    (I_data),
    .O_data    (O_data),
    .O_oe      (O_oe),
    .O_rd_val  (O_rd_val),
    .I_rd_rdy  (I_rd_rdy),
    .I_wr_val  (I_wr_val),
    .O_wr_rdy  (O_wr_rdy),
    .I_len_tbl (I_len_tbl),
    .I_dir_tbl (I_dir_tbl),
    .I_pat_tbl (I_pat_tbl),
    .O_busy    (O_busy),
    .O_done    (O_done),
    .O_timeout (O_timeout),
    .O_mode    (O_mode),
    .O_beat_cnt(O_beat_cnt),
    .O_rx_sig  (O_rx_sig)
  );

  initial I_clk = 1'b0;
  always #5 I_clk = ~I_clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Observations captured by the most recent transfer.
  logic [DATA_W-1:0] cap_word [2];
  logic [CNT_W-1:0]  done_cnt;
  logic              done_tmo;
  logic [DATA_W-1:0] done_rx;

  function automatic logic [DATA_W-1:0] rand_word();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [DATA_W-1:0] exp_word(input int pat, input int b);
    logic [DATA_W-1:0] w = '0;
    for (int k = 0; k < LANES; k++) begin
      int v;
      case (pat)
        0:       v = 0;
        1:       v = (b * 2 * LANES + 2 * k) % 65536;
        2:       v = 'h0101;
        default: v = 'hAAAA;
      endcase
      w[k*16 +: 16] = 16'(v);
    end
    return w;
  endfunction

  task automatic scramble_tables();
    logic [DATA_W-1:0] t;
    t = rand_word();
    I_len_tbl = t[NUM_MODES*CNT_W-1:0];
    t = rand_word();
    I_dir_tbl = t[NUM_MODES-1:0];
    I_pat_tbl = t[NUM_MODES*2+7:8];
  endtask

  task automatic check_all_zero(input string p);
    check({p, "_cfg_rdy"},  O_cfg_rdy,  0);
    check({p, "_rd_val"},   O_rd_val,   0);
    check({p, "_wr_rdy"},   O_wr_rdy,   0);
    check({p, "_oe"},       O_oe,       0);
    check({p, "_busy"},     O_busy,     0);
    check({p, "_done"},     O_done,     0);
    check({p, "_timeout"},  O_timeout,  0);
    check({p, "_mode"},     O_mode,     0);
    check({p, "_beat_cnt"}, O_beat_cnt, 0);
    check({p, "_rx_sig"},   O_rx_sig,   0);
    check({p, "_data"},     O_data,     0);
  endtask

  // One complete transfer; called and returning on a falling edge.
  task automatic run_xfer(input int mode, input int len, input int dir, input int pat,
                          input int policy, input int hold_cfg, input int abort_at,
                          input int data_is_index);
    int b = 0;
    int idle = 0;
    int cyc = 0;
    logic finished = 1'b0;
    logic tmo = 1'b0;
    logic [DATA_W-1:0] rx = '0;
    logic [DATA_W-1:0] d;
    logic drv;

    I_len_tbl[mode*CNT_W +: CNT_W] = CNT_W'(len);
    I_dir_tbl[mode]                = dir[0];
    I_pat_tbl[mode*2 +: 2]         = 2'(pat);

    for (int w = 0; w < 20 && !O_cfg_rdy; w++) @(negedge I_clk);
    check("cfg_rdy_wait", O_cfg_rdy, 1);
    d = rand_word();
    d[MODE_W:1] = MODE_W'(mode);
    I_data    = d;
    I_cfg_val = 1'b1;
    @(negedge I_clk);
    if (hold_cfg == 0) I_cfg_val = 1'b0;
    scramble_tables();

    while (!finished && cyc < 3000) begin
      if (abort_at >= 0 && b == abort_at) begin
        I_rst = 1'b1;
        #1;
        check_all_zero("abort");
        @(negedge I_clk);
        I_rst     = 1'b0;
        I_cfg_val = 1'b0;
        I_rd_rdy  = 1'b0;
        I_wr_val  = 1'b0;
        @(negedge I_clk);
        check("abort_cfg_rdy", O_cfg_rdy, 1);
        check("abort_done", O_done, 0);
        return;
      end

      check("busy",       O_busy,     1);
      check("done_early", O_done,     0);
      check("cfg_rdy",    O_cfg_rdy,  0);
      check("mode",       O_mode,     mode);
      check("rd_val",     O_rd_val,   dir);
      check("wr_rdy",     O_wr_rdy,   (dir == 0));
      check("oe",         O_oe,       dir);
      check("data",       O_data,     (dir != 0) ? exp_word(pat, b) : '0);
      check("beat_cnt",   O_beat_cnt, b);
      check("rx_sig",     O_rx_sig,   rx);
      check("timeout",    O_timeout,  0);
      if (b < 2) cap_word[b] = O_data;

      case (policy)
        P_ALWAYS:  drv = 1'b1;
        P_RANDOM:  drv = 1'($urandom_range(0, 1));
        P_NEVER:   drv = 1'b0;
        P_EVERY15: drv = (idle == TMO_IDLE - 1);
        default:   drv = cyc[0];
      endcase
      d = (data_is_index != 0) ? DATA_W'(b) : rand_word();
      I_data   = d;
      I_rd_rdy = (dir != 0) ? drv : 1'($urandom_range(0, 1));
      I_wr_val = (dir != 0) ? 1'($urandom_range(0, 1)) : drv;
      @(negedge I_clk);
      cyc++;

      if (drv) begin
        if (dir == 0) rx ^= d;
        b++;
        idle = 0;
        if (b == len + 1) finished = 1'b1;
      end else begin
        idle++;
        if (idle == TMO_IDLE) begin
          finished = 1'b1;
          tmo      = 1'b1;
        end
      end
    end
    check("xfer_bound", finished, 1);

    I_rd_rdy = 1'b0;
    I_wr_val = 1'b0;
    check("done_pulse",    O_done,     1);
    check("done_busy",     O_busy,     1);
    check("done_cfg_rdy",  O_cfg_rdy,  0);
    check("done_oe",       O_oe,       0);
    check("done_rd_val",   O_rd_val,   0);
    check("done_wr_rdy",   O_wr_rdy,   0);
    check("done_data",     O_data,     0);
    check("done_beat_cnt", O_beat_cnt, (b > CNT_MAX) ? CNT_MAX : b);
    check("done_timeout",  O_timeout,  tmo);
    check("done_rx_sig",   O_rx_sig,   rx);
    done_cnt = O_beat_cnt;
    done_tmo = O_timeout;
    done_rx  = O_rx_sig;
    @(negedge I_clk);
    check("idle_done",    O_done,    0);
    check("idle_busy",    O_busy,    0);
    check("idle_cfg_rdy", O_cfg_rdy, 1);
    check("idle_timeout", O_timeout, tmo);
  endtask

  initial begin
    #400000;
    $display("FAIL global_time_limit: got running expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    I_rst     = 1'b1;
    I_cfg_val = 1'b0;
    I_data    = '0;
    I_rd_rdy  = 1'b0;
    I_wr_val  = 1'b0;
    scramble_tables();
    repeat (3) @(negedge I_clk);
    check_all_zero("reset");
    I_rst = 1'b0;
    @(negedge I_clk);
    check("post_reset_cfg_rdy", O_cfg_rdy, 1);
    check("post_reset_busy", O_busy, 0);

    // Host-send ramp burst with receiver always ready.
    run_xfer(3, 53, 1, 1, P_ALWAYS, 0, -1, 0);
    check("ramp_beats", done_cnt, 54);
    check("ramp_b0_lane7", cap_word[0][7*16 +: 16], 16'h000E);
    check("ramp_b1_lane0", cap_word[1][15:0], 16'h0010);
    check("ramp_no_tmo", done_tmo, 0);

    // Host-receive, data = beat index, valid toggling: XOR of 0..63 is zero.
    run_xfer(1, 63, 0, 2, P_TOGGLE, 0, -1, 1);
    check("rx_beats", done_cnt, 64);
    check("rx_sig_zero", done_rx, 0);

    // Receiver never ready: watchdog ends the transfer.
    run_xfer(2, 3, 1, 3, P_NEVER, 0, -1, 0);
    check("tmo_flag", done_tmo, 1);
    check("tmo_beats", done_cnt, 0);

    // A beat on the last watchdog cycle must rescue the transfer, both directions.
    run_xfer(4, 5, 1, 2, P_EVERY15, 0, -1, 0);
    check("rescue_send_tmo", done_tmo, 0);
    check("rescue_send_beats", done_cnt, 6);
    run_xfer(5, 3, 0, 0, P_EVERY15, 0, -1, 0);
    check("rescue_recv_tmo", done_tmo, 0);
    check("rescue_recv_beats", done_cnt, 4);

    // Reset at beat 10, then a fresh transfer must be accepted.
    run_xfer(5, 30, 1, 1, P_ALWAYS, 0, 10, 0);
    run_xfer(6, 7, 0, 1, P_RANDOM, 0, -1, 0);
    check("after_abort_beats", done_cnt, 8);

    // cfg_val held high through a transfer: no re-latch; next one back-to-back.
    run_xfer(6, 20, 0, 0, P_RANDOM, 1, -1, 0);
    run_xfer(7, 12, 1, 3, P_ALWAYS, 0, -1, 0);
    check("back_to_back_beats", done_cnt, 13);

    // Maximum length: beat counter saturates.
    run_xfer(0, CNT_MAX, 1, 1, P_ALWAYS, 0, -1, 0);
    check("sat_beats", done_cnt, CNT_MAX);

    for (int i = 0; i < 25; i++) begin
      int pol;
      case ($urandom_range(0, 2))
        0:       pol = P_ALWAYS;
        1:       pol = P_RANDOM;
        default: pol = P_TOGGLE;
      endcase
      run_xfer($urandom_range(0, NUM_MODES - 1), $urandom_range(0, 40), $urandom_range(0, 1),
               $urandom_range(0, 3), pol, 0, -1, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
